// File: rtl/bcd_7seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan
//
// Display-side consumer for the pipelined binary-to-BCD converter chain.
// Captures a settled BCD result (digits plus converter carry-out) on a load
// strobe. It drives that result onto a common-segment 7-segment display, one
// digit at a time, with a one-hot digit select. Each digit slot has a
// one-cycle dark gap before it to suppress ghosting. The block also provides
// leading-zero blanking and an error flag.
//
// Parameters
//   numberOfDigits : number of BCD digits displayed (>= 1)
//   scanDiv        : cycles each digit stays lit per scan slot (>= 1)
//
// Ports
//   i_clk       in   clock, all state updates on the rising edge
//   i_rst       in   synchronous active-low reset
//   i_digitIn   in   BCD digits from the converter, digit 0 least significant
//   i_digitCIn  in   converter carry-out (overflow)
//   i_load      in   capture strobe
//   i_blankEn   in   leading-zero blanking enable
//   o_segOut    out  segments {g,f,e,d,c,b,a}, active-high
//   o_digitSel  out  one-hot digit enable, bit k = digit k
//   o_loadAck   out  one-cycle pulse after each capture
//   o_errOut    out  captured value is overflow or holds a digit > 9
// ---------------------------------------------------------------------------
module bcd_7seg_scan #(
  parameter int numberOfDigits = 3,
  parameter int scanDiv        = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [numberOfDigits-1:0][3:0] i_digitIn,
  input  logic                           i_digitCIn,
  input  logic                           i_load,
  input  logic                           i_blankEn,
  output logic [6:0]                     o_segOut,
  output logic [numberOfDigits-1:0]      o_digitSel,
  output logic                           o_loadAck,
  output logic                           o_errOut
);

  localparam int IDX_W = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
  localparam int CNT_W = (scanDiv > 1) ? $clog2(scanDiv) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(numberOfDigits - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(scanDiv - 1);

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [CNT_W-1:0]                 r_cnt;
  logic [numberOfDigits-1:0][3:0]   r_digits;
  logic                             r_carry;
  logic                             r_blank;
  logic                             r_load_d;
  logic                             r_ack;
  logic                             r_err;
  logic [6:0]                       r_seg;
  logic [numberOfDigits-1:0]        r_sel;

  logic [numberOfDigits-1:0]        w_bad_digit;
  logic [numberOfDigits-1:0][6:0]   w_seg_digit;
  logic                             w_zero_run;
  logic [6:0]                       w_seg_cur;
  logic [numberOfDigits-1:0]        w_sel_cur;
  logic                             w_err_next;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < numberOfDigits; gi++) begin : g_bad
      assign w_bad_digit[gi] = (r_digits[gi] > 4'd9);
    end
  endgenerate

  // Segment pattern for every digit of the captured value. Walking from the
  // most significant digit down, w_zero_run stays high while all digits seen
  // so far (k..top) are zero, which is exactly the blanking condition.
  always_comb begin
    w_zero_run  = 1'b1;
    w_seg_digit = '0;
    for (int k = numberOfDigits - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_digits[k] == 4'd0);
      if (r_carry || w_bad_digit[k]) begin
        w_seg_digit[k] = 7'h40;
      end else if (r_blank && (k > 0) && w_zero_run) begin
        w_seg_digit[k] = 7'h00;
      end else begin
        w_seg_digit[k] = decode7(r_digits[k]);
      end
    end
  end

  assign w_seg_cur  = w_seg_digit[r_idx];
  assign w_sel_cur  = numberOfDigits'(1) << r_idx;
  assign w_err_next = r_carry | (|w_bad_digit);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= GAP;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_carry  <= 1'b0;
      r_blank  <= 1'b0;
      r_load_d <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_seg    <= '0;
      r_sel    <= '0;
    end else begin
      if (i_load) begin
        r_digits <= i_digitIn;
        r_carry  <= i_digitCIn;
      end
      r_blank  <= i_blankEn;
      // Two-stage so the ack and error flag line up with the first
      // displayed cycle of the new value.
      r_load_d <= i_load;
      r_ack    <= r_load_d;
      r_err    <= w_err_next;

      case (r_state)
        GAP: begin
          r_state <= SHOW;
          r_cnt   <= '0;
          r_sel   <= w_sel_cur;
          r_seg   <= w_seg_cur;
        end
        SHOW: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= GAP;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            r_sel   <= '0;
            r_seg   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_sel <= w_sel_cur;
            r_seg <= w_seg_cur;
          end
        end
        default: begin
          r_state <= GAP;
          r_sel   <= '0;
          r_seg   <= '0;
        end
      endcase
    end
  end

  assign o_segOut   = r_seg;
  assign o_digitSel = r_sel;
  assign o_loadAck  = r_ack;
  assign o_errOut   = r_err;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

  localparam int N     = 3;
  localparam int D     = 4;
  localparam int FRAME = N * (D + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0][3:0]  digit_in = '0;
  logic               carry_in = 1'b0;
  logic               load = 1'b0;
  logic               blank_en = 1'b0;
  logic [6:0]         seg_out;
  logic [N-1:0]       digit_sel;
  logic               load_ack;
  logic               err_out;

  bcd_7seg_scan #(.numberOfDigits(N), .scanDiv(D)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_digitIn  (digit_in),
    .i_digitCIn (carry_in),
    .i_load     (load),
    .i_blankEn  (blank_en),
    .o_segOut   (seg_out),
    .o_digitSel (digit_sel),
    .o_loadAck  (load_ack),
    .o_errOut   (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] sel;
    logic         ack;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  // Reference model state: frame position and the captured value as seen
  // by the outputs after the coming edge.
  int                m_pos = 0;
  logic [N-1:0][3:0] m_cap = '0;
  logic              m_carry = 1'b0;
  logic              m_load_prev = 1'b0;
  logic              m_blank = 1'b0;
  logic              cur_blank = 1'b0;
  logic [N-1:0][3:0] cur_digits = '0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input int k);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = k; j < N; j++)
      if (m_cap[j] != 4'd0) all_zero = 1'b0;
    if (m_carry) return 7'h40;
    if (m_cap[k] > 4'd9) return 7'h40;
    if (m_blank && k > 0 && all_zero) return 7'h00;
    return seg_of(m_cap[k]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n_cycle, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, push the expected outputs for the coming
  // edge, then pop and compare once the DUT has updated.
  task automatic step(input logic l, input logic [N-1:0][3:0] d, input logic c,
                      input logic b, input logic r);
    exp_t e;
    exp_t got;
    int   p;
    int   ph;
    int   slot;
    logic any_bad;
    @(negedge clk);
    load = l; digit_in = d; carry_in = c; blank_en = b; rst = r;
    if (!r) begin
      e.seg = '0; e.sel = '0; e.ack = 1'b0; e.err = 1'b0;
      m_pos = 0; m_cap = '0; m_carry = 1'b0; m_load_prev = 1'b0; m_blank = 1'b0;
    end else begin
      p    = (m_pos + 1) % FRAME;
      ph   = p % (D + 1);
      slot = p / (D + 1);
      if (ph == 0) begin
        e.seg = '0;
        e.sel = '0;
      end else begin
        e.seg = ref_seg(slot);
        e.sel = N'(1) << slot;
      end
      any_bad = 1'b0;
      for (int j = 0; j < N; j++)
        if (m_cap[j] > 4'd9) any_bad = 1'b1;
      e.ack = m_load_prev;
      e.err = m_carry | any_bad;
      m_pos = p;
      if (l) begin
        m_cap   = d;
        m_carry = c;
      end
      m_load_prev = l;
      m_blank     = b;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cycle++;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard cycle %0d: observed empty queue expected entry", n_cycle);
    end else begin
      got = exp_q.pop_front();
      check("segOut",   32'(seg_out),   32'(got.seg));
      check("digitSel", 32'(digit_sel), 32'(got.sel));
      check("loadAck",  32'(load_ack),  32'(got.ack));
      check("errOut",   32'(err_out),   32'(got.err));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_digits, 1'b0, cur_blank, 1'b1);
  endtask

  task automatic load_val(input logic [N-1:0][3:0] d, input logic c);
    cur_digits = d;
    step(1'b1, d, c, cur_blank, 1'b1);
  endtask

  initial begin
    // Reset, then one idle frame showing 0 on every digit.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(FRAME + 2);

    // Plain value, no blanking.
    load_val({4'd2, 4'd0, 4'd7}, 1'b0);
    idle(FRAME);

    // Enable blanking while the top digit is non-zero, then load leading zeros.
    cur_blank = 1'b1;
    idle(2);
    load_val({4'd0, 4'd0, 4'd5}, 1'b0);
    idle(FRAME);
    load_val({4'd0, 4'd4, 4'd0}, 1'b0);
    idle(FRAME);

    // Overflow: dashes everywhere, blanking ignored.
    load_val({4'd9, 4'd9, 4'd9}, 1'b1);
    idle(FRAME);
    cur_blank = 1'b0;
    idle(2);
    // Non-BCD digit.
    load_val({4'd0, 4'd0, 4'hA}, 1'b0);
    idle(FRAME);

    // Load at an arbitrary point mid-scan.
    idle(3);
    load_val({4'd3, 4'd8, 4'd1}, 1'b0);
    idle(8);

    // Reset mid-frame with a concurrent load that must be discarded.
    step(1'b1, {4'd6, 4'd6, 4'd6}, 1'b0, cur_blank, 1'b0);
    cur_digits = '0;
    idle(FRAME + 1);

    // Back-to-back loads with changing data.
    for (int i = 0; i < 10; i++)
      load_val({4'(i % 10), 4'((i + 3) % 10), 4'((7 * i) % 10)}, 1'b0);
    idle(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Display-side consumer for the pipelined binary-to-BCD converter chain. Captures a settled BCD result (digits plus converter carry-out) on a load strobe and time-multiplexes it onto a common-segment 7-segment display with one-hot digit select. Provides leading-zero blanking, a one-cycle inter-digit ghosting gap, and an error flag for overflow or non-BCD digits.

## Interface
- numberOfDigits, 3, number of BCD digits displayed; must match the converter width; ≥1
- scanDiv, 4, cycles each digit stays lit per scan slot; ≥1

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- digitIn  in  [numberOfDigits-1:0][3:0]  BCD digits from converter, digit 0 least significant
- digitCIn  in  1  converter carry-out (overflow)
- load  in  1  capture strobe, sampled every edge
- blankEn  in  1  leading-zero blanking enable, sampled live
- segOut  out  7  segments {g,f,e,d,c,b,a}, bit0 = a, active-high
- digitSel  out  numberOfDigits  one-hot digit enable, active-high, bit k = digit k
- loadAck  out  1  one-cycle pulse after each capture
- errOut  out  1  captured value is overflow or contains a digit > 9

## Operation
- Capture register: on an edge with load=1, store digitIn and digitCIn; otherwise hold. Scan position is never disturbed by load.
- errOut: registered with the capture; 1 iff the captured carry = 1 or any captured digit > 9.
- Scan FSM states: GAP, SHOW. Digit index idx in 0..numberOfDigits-1; prescale counter cnt in 0..scanDiv-1.
  - GAP: digitSel = 0, segOut = 0; lasts exactly one cycle; next SHOW with cnt = 0, same idx.
  - SHOW: digitSel = one-hot(idx), segOut = decode(idx); cnt increments each cycle; at cnt = scanDiv-1 go to GAP and idx ← idx+1, wrapping numberOfDigits-1 → 0.
- Decode for digit k:
  - captured carry = 1: 0x40 (dash) on every digit.
  - captured digit > 9: 0x40 on that digit.
  - blanked: 0x00. Digit k is blanked iff blankEn = 1, k > 0, carry = 0, and captured digits k..numberOfDigits-1 are all 0. Digit 0 is never blanked.
  - else 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F.
- While blanked, digitSel is still asserted for that slot; only segOut is 0.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Reset (rst = 0 at an edge): state GAP, idx = 0, cnt = 0, captured digits = 0, captured carry = 0; segOut = 0, digitSel = 0, loadAck = 0, errOut = 0.
- After reset release: cycle 0 is GAP; cycles 1..scanDiv show digit 0; cycle scanDiv+1 is GAP; then digit 1; and so on. Slot period is scanDiv+1 cycles; frame period is numberOfDigits·(scanDiv+1) cycles.
- Capture latency: load = 1 at edge E updates the capture register at E. loadAck, errOut, and the segOut of a SHOW cycle take the new value at edge E+1.
- Back-to-back loads capture every cycle; loadAck stays high throughout. A load during GAP is accepted normally.
- blankEn change at edge E affects segOut from edge E+1.
- rst = 0 mid-scan or mid-load: the reset values win at that edge; any concurrent load is discarded.
- numberOfDigits = 1: idx stays at 0, and GAP still occurs once per slot.

## Test plan
- Reset then idle, numberOfDigits = 3, scanDiv = 4, blankEn = 0 → digitSel sequence 000, 001×4, 000, 010×4, 000, 100×4, repeat; segOut = 0x3F in every SHOW cycle; errOut = 0.
- Load digits {2,0,7} (digit 2..0), carry 0, blankEn = 0 → loadAck one cycle; digit 0 shows 0x07, digit 1 shows 0x3F, digit 2 shows 0x5B.
- Load {0,0,5}, blankEn = 1 → digit 0 shows 0x6D; digits 1 and 2 show 0x00 with digitSel asserted. Load {0,4,0} → digit 0 = 0x3F, digit 1 = 0x66, digit 2 = 0x00.
- Load carry = 1 with digits {9,9,9} → errOut = 1 on the next edge; all digits show 0x40 with blanking ignored. Load {0,0,0xA} with carry 0 → digit 0 = 0x40, errOut = 1.
- Assert load mid-SHOW of digit 1 with a new value → the scan position is unchanged and segOut changes on the next edge. Assert rst = 0 mid-frame → all outputs return to 0 at that edge, and the scan restarts with GAP then digit 0.
- Hold load high for 10 cycles with digitIn changing each cycle → loadAck is high all 10 cycles; segOut tracks the value captured one edge earlier.
